// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter.
// Operation encoding as seen on in_op.
package barrel_pkg;

    localparam int SHIFT_OP_W = 2;

    typedef enum logic [SHIFT_OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/barrel_stage.sv
// One elastic stage of the barrel shifter: shifts by 2^K when shift bit K
// is set, then registers the result behind a valid/ready slice.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NSHIFTS = 3,
    parameter int K       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NBITS-1:0]   in_data,
    input  logic [NSHIFTS-1:0] in_shift,
    input  shift_op_t          in_op,
`ifdef BARREL_CARRY_EN
    input  logic               in_carry,
    output logic               out_carry,
`endif
    input  logic               in_valid,
    input  logic               dn_ready,
    output logic [NBITS-1:0]   out_data,
    output logic [NSHIFTS-1:0] out_shift,
    output shift_op_t          out_op,
    output logic               out_valid
);

    localparam int SH = 1 << K;
    localparam int RA = SH % NBITS;

    logic [NBITS-1:0]   data_d, data_q;
    logic [NSHIFTS-1:0] shift_q;
    shift_op_t          op_q;
    logic               valid_q;
    logic               load;

    always_comb begin
        data_d = in_data;
        if (in_shift[K]) begin
            unique case (in_op)
                OP_SLL: data_d = in_data << SH;
                OP_SRL: data_d = in_data >> SH;
                OP_SRA: data_d = $signed(in_data) >>> SH;
                OP_ROL: data_d = (in_data << RA) | (in_data >> (NBITS - RA));
            endcase
        end
    end

    assign load = ~valid_q | dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shift_q <= '0;
            op_q    <= OP_SLL;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= data_d;
                shift_q <= in_shift;
                op_q    <= in_op;
            end
        end
    end

`ifdef BARREL_CARRY_EN
    // Last bit out of a 2^K shift is the one sitting at the edge after 2^K-1.
    logic [NBITS-1:0] lsh, rsh, ash;
    logic             carry_d, carry_q;

    always_comb begin
        lsh     = in_data << (SH - 1);
        rsh     = in_data >> (SH - 1);
        ash     = $signed(in_data) >>> (SH - 1);
        carry_d = in_carry;
        if (in_shift[K]) begin
            unique case (in_op)
                OP_SLL: carry_d = lsh[NBITS-1];
                OP_SRL: carry_d = rsh[0];
                OP_SRA: carry_d = ash[0];
                OP_ROL: carry_d = (RA != 0) ? data_d[0] : in_carry;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (load && in_valid) begin
            carry_q <= carry_d;
        end
    end

    assign out_carry = carry_q;
`endif

    assign out_data  = data_q;
    assign out_shift = shift_q;
    assign out_op    = op_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Elastic NSHIFTS-stage barrel shifter (SLL/SRL/SRA/ROL), one op per cycle.
// Define BARREL_CARRY_EN to add out_carry, the last bit shifted out.
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NSHIFTS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NBITS-1:0]   in_data,
    input  logic [NSHIFTS-1:0] in_shift,
    input  logic [1:0]         in_op,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NBITS-1:0]   out_data,
    output logic               out_valid,
`ifdef BARREL_CARRY_EN
    output logic               out_carry,
`endif
    input  logic               out_ready
);

    logic [NBITS-1:0]   dat [NSHIFTS+1];
    logic [NSHIFTS-1:0] shf [NSHIFTS+1];
    shift_op_t          opc [NSHIFTS+1];
    logic [NSHIFTS:0]   vld;
    logic [NSHIFTS:0]   rdy;
`ifdef BARREL_CARRY_EN
    logic [NSHIFTS:0]   cry;
`endif
    logic               unused_tail;

    assign dat[0] = in_data;
    assign shf[0] = in_shift;
    assign opc[0] = shift_op_t'(in_op);
    assign vld[0] = in_valid;
`ifdef BARREL_CARRY_EN
    assign cry[0] = 1'b0;
`endif

    // Ready ripples back: a stage can load if empty or draining this cycle.
    always_comb begin
        rdy          = '0;
        rdy[NSHIFTS] = out_ready;
        for (int k = NSHIFTS - 1; k >= 0; k--) begin
            rdy[k] = ~vld[k+1] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < NSHIFTS; k++) begin : g_stage
        barrel_stage #(
            .NBITS   (NBITS),
            .NSHIFTS (NSHIFTS),
            .K       (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (dat[k]),
            .in_shift  (shf[k]),
            .in_op     (opc[k]),
`ifdef BARREL_CARRY_EN
            .in_carry  (cry[k]),
            .out_carry (cry[k+1]),
`endif
            .in_valid  (vld[k]),
            .dn_ready  (rdy[k+1]),
            .out_data  (dat[k+1]),
            .out_shift (shf[k+1]),
            .out_op    (opc[k+1]),
            .out_valid (vld[k+1])
        );
    end

    assign in_ready    = rdy[0];
    assign out_data    = dat[NSHIFTS];
    assign out_valid   = vld[NSHIFTS];
`ifdef BARREL_CARRY_EN
    assign out_carry   = cry[NSHIFTS];
`endif
    assign unused_tail = ^{shf[NSHIFTS], opc[NSHIFTS]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed-vector bench for pipelined_barrel_shifter (NBITS=8, NSHIFTS=3).
// Carry checks are compiled in only when BARREL_CARRY_EN is defined.
module tb_pipelined_barrel_shifter;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [2:0] in_shift;
    logic [1:0] in_op;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       cw;
`ifdef BARREL_CARRY_EN
    logic       out_carry;
    assign cw = out_carry;
`else
    assign cw = 1'b0;
`endif

    pipelined_barrel_shifter #(
        .NBITS   (8),
        .NSHIFTS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef BARREL_CARRY_EN
        .out_carry (out_carry),
`endif
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] d;
        logic       c;
        int         cy;
    } res_t;

    res_t got_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    // Directed stream: data, shift, op -> expected data, carry.
    logic [7:0] v_d [8] = '{8'h81, 8'h80, 8'h80, 8'h7F, 8'h81, 8'hA5, 8'h0F, 8'hF0};
    logic [2:0] v_s [8] = '{3'd1, 3'd3, 3'd3, 3'd7, 3'd1, 3'd0, 3'd4, 3'd5};
    logic [1:0] v_o [8] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
    logic [7:0] e_d [8] = '{8'h02, 8'hF0, 8'h10, 8'h00, 8'h03, 8'hA5, 8'hF0, 8'h07};
    logic       e_c [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Backpressure set: ROL by 4 swaps nibbles.
    logic [7:0] b_d [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    logic [7:0] b_e [6] = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic got, input logic exp);
`ifdef BARREL_CARRY_EN
        chk(tag, 32'(got), 32'(exp));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] s,
                         input logic [1:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_op    = o;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) got_q.push_back('{out_data, cw, cyc});
        if (in_valid && in_ready) n_acc++;
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_op     = '0;
        out_ready = 1'b1;

        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk_c("rst_carry", cw, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 1);
        tick();

        // Latency: accepted at edge t, visible after t+2.
        drive(8'h81, 3'd1, 2'b00);
        tick();
        in_valid = 1'b0;
        chk("lat_t0", 32'(out_valid), 0);
        tick();
        chk("lat_t1", 32'(out_valid), 0);
        tick();
        chk("lat_t2_v", 32'(out_valid), 1);
        chk("lat_t2_d", 32'(out_data), 32'h02);
        chk_c("lat_t2_c", cw, 1'b1);
        tick();
        tick();
        got_q.delete();

        // Back-to-back stream, no bubbles expected.
        for (int i = 0; i < 8; i++) begin
            drive(v_d[i], v_s[i], v_o[i]);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("strm_n", 32'(got_q.size()), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            chk($sformatf("strm_d%0d", i), 32'(got_q[i].d), 32'(e_d[i]));
            chk_c($sformatf("strm_c%0d", i), got_q[i].c, e_c[i]);
            chk($sformatf("strm_gap%0d", i), 32'(got_q[i].cy - got_q[0].cy), 32'(i));
        end

        // Backpressure: out_ready low for 6 cycles.
        got_q.delete();
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (n_acc < 6);
            in_data  = (n_acc < 6) ? b_d[n_acc] : 8'h00;
            in_shift = 3'd4;
            in_op    = 2'b11;
            tick();
        end
        chk("bp_acc", 32'(n_acc), 3);
        chk("bp_ready", 32'(in_ready), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_hold", 32'(out_data), 32'h21);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && got_q.size() < 6; i++) begin
            in_valid = (n_acc < 6);
            in_data  = (n_acc < 6) ? b_d[n_acc] : 8'h00;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_n", 32'(got_q.size()), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk($sformatf("bp_d%0d", i), 32'(got_q[i].d), 32'(b_e[i]));
            chk_c($sformatf("bp_c%0d", i), got_q[i].c, 1'b1);
        end
        tick();
        tick();

        // Asynchronous reset with two ops in flight.
        drive(8'h81, 3'd1, 2'b00);
        tick();
        drive(8'hA5, 3'd0, 2'b11);
        tick();
        in_valid = 1'b0;
        tick();
        chk("inflt_v", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        tick();
        tick();
        got_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("no_stale", 32'(got_q.size()), 0);

        drive(8'h80, 3'd3, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("rlat_t0", 32'(out_valid), 0);
        tick();
        chk("rlat_t1", 32'(out_valid), 0);
        tick();
        chk("rlat_t2_v", 32'(out_valid), 1);
        chk("rlat_t2_d", 32'(out_data), 32'hF0);
        chk_c("rlat_t2_c", cw, 1'b0);
        tick();
        tick();
        chk("rlat_n", 32'(got_q.size()), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, multi-mode successor to the combinational log-shifter: NSHIFTS cascaded stages, stage i shifting by 2^i.
- Every stage is registered, giving latency NSHIFTS and throughput of one operation per cycle.
- Stages are linked by a valid/ready elastic pipeline, so the block can sit between a decode unit and a downstream consumer that applies backpressure.
- Supports logical left, logical right, arithmetic right and rotate-left.

Parameters:
NBITS, 8, data width in bits (>= 2).
NSHIFTS, 3, shift-amount width and number of stages; amounts 0 .. 2^NSHIFTS-1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  NBITS  operand.
in_shift  input  NSHIFTS  shift amount.
in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
in_valid  input  1  operand valid.
in_ready  output  1  block can accept this cycle.
out_data  output  NBITS  result.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_carry  output  1  last bit shifted out (only with BARREL_CARRY_EN).

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit. out_valid = 0, out_data = 0, out_carry = 0. in_ready = 1 once reset is released.
- Transfer rules: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
- Stage k (0..NSHIFTS-1) holds {data, remaining shift bits, op, valid}. It applies shift bit k as a shift by 2^k.
- Stage k loads when it is empty or its content moves to stage k+1 (or out) the same cycle: ready_k = ~valid_k | ready_(k+1); ready_NSHIFTS = out_ready; in_ready = ready_0.
- Latency: a transfer accepted at edge t is presented on out_* after edge t+NSHIFTS-1, i.e. NSHIFTS register stages, with no stall.
- Full throughput: back-to-back inputs with out_ready high give one result per cycle.
- Order preserved; no drops or duplicates.
- Backpressure: with out_ready low, at most NSHIFTS operations are held; in_ready falls once all stages are valid.
- Stalled registers hold their value; out_data stays stable while out_valid && !out_ready.
- Fill rules:
  - SLL and SRL shift in zeros.
  - SRA shifts in in_data[NBITS-1].
  - ROL wraps bits; the amount is taken modulo NBITS.
- Amounts >= NBITS (possible when 2^NSHIFTS > NBITS): SLL/SRL yield 0; SRA yields all sign bits; ROL yields rotate by (amount mod NBITS).
- Shift amount 0 passes data unchanged for every op.
- in_op = SRA on a positive value behaves as SRL.
- Reset mid-operation: all in-flight operations are discarded; nothing from before reset is ever emitted.
- in_* are ignored while in_ready is low.

Optional Feature:
Macro BARREL_CARRY_EN.
- Defined: port out_carry exists and travels with the data through the pipeline. Its value is the last bit shifted out:
  - SLL by s, 1<=s<=NBITS: in[NBITS-s]; 0 for s > NBITS.
  - SRL by s, 1<=s<=NBITS: in[s-1]; 0 for s > NBITS.
  - SRA by s: in[s-1] for 1<=s<=NBITS; in[NBITS-1] for s > NBITS.
  - ROL with effective amount != 0: out_data[0].
  - Shift 0: 0.
- Undefined: out_carry port and its per-stage flops are absent; all other behaviour is identical.

Decomposition:
- Package barrel_pkg holds:
  - enum shift_op_t {OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11};
  - constant SHIFT_OP_W = 2.
- Sub-module barrel_stage:
  - one registered stage parametrised by NBITS and stage index k;
  - combinational shift by 2^k (gated by its shift bit) plus the valid/ready register slice and optional carry flop.
- The top instantiates NSHIFTS barrel_stage instances in a generate loop.

Test Plan:
(All scenarios use NBITS=8, NSHIFTS=3.)
- SLL 0x81 by 1, out_ready=1 -> out_data=0x02 exactly 3 cycles after accept; out_carry=1.
- SRA 0x80 by 3 -> 0xF0; SRL 0x80 by 3 -> 0x10, carry 0; SRA 0x7F by 7 -> 0x00, carry 1.
- ROL 0x81 by 1 -> 0x03; ROL 0xA5 by 0 -> 0xA5, carry 0.
- Stream 8 random ops back-to-back with out_ready=1 -> 8 consecutive valid outputs matching the reference model, no bubbles.
- Hold out_ready=0 for 6 cycles while driving in_valid=1 -> in_ready drops after 3 accepts, out_data stable; on release all results arrive in order, none lost.
- Assert rst_n=0 mid-cycle with 2 operations in flight -> out_valid=0 immediately (asynchronous); after release no stale result appears, and the first new op emerges with latency 3.
